pa_mem_agent: RTL and testbench

//  Memory-side responder for the PA sequencer's three handshakes. It serves the

---
 rtl/pa_mem_agent.sv | 222 ++++++++++++++++++++++
 tb/tb_pa_mem_agent.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_mem_agent.sv
// pa_mem_agent: memory-side responder for the PA sequencer.
// Prefetches the weight stream and the data segment through a req/gnt/rvalid
// memory port into a first-word-fall-through FIFO, then sinks result writes.
// Optional feature macro: PA_AGENT_PERF_CNT_EN (enables the perf_stall counter).
//
// Handshakes: a read word transfers on every cycle where *_rd_rdy & *_rd_acq
// are both high at the clock edge; a result transfers on dst_wr_rdy &
// dst_wr_acq. On the memory side mem_req/mem_we/mem_addr/mem_wdata are held
// stable until the cycle mem_gnt is seen high.
module pa_mem_agent #(
  parameter int AW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_load,
  input  logic          d_load,
  input  logic [AW-1:0] cfg_w_base,
  input  logic [31:0]   cfg_w_len,
  input  logic [AW-1:0] cfg_d_base,
  input  logic [31:0]   cfg_d_len,
  input  logic [AW-1:0] cfg_o_base,
  input  logic [31:0]   cfg_o_len,
  input  logic          weight_rd_acq,
  output logic          weight_rd_rdy,
  input  logic          data_rd_acq,
  output logic          data_rd_rdy,
  output logic [31:0]   rd_data,
  input  logic          dst_wr_rdy,
  input  logic [31:0]   dst_wr_data,
  output logic          dst_wr_acq,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   perf_stall,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_W_FETCH = 2'd1,
    S_D_FETCH = 2'd2,
    S_WB      = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_rd_addr, r_d_base, r_o_ptr;
  logic [31:0]   r_remain, r_d_len, r_o_len, r_wr_cnt, r_wdata;
  logic          r_wr_pend, r_done, r_err;
  logic [CW-1:0] r_count, r_outstanding;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_fifo [DEPTH];

  logic          w_empty, w_fetching, w_credit, w_rd_req, w_rd_gnt, w_wr_gnt;
  logic          w_push, w_pop, w_fetch_done, w_w_ok, w_d_ok, w_load_err, w_wr_take;
  logic          w_idle_or_wb;
  logic [CW:0]   w_inflight;
  logic [AW-1:0] w_nd_base;
  logic [31:0]   w_nd_len;

  assign w_empty      = (r_count == '0);
  assign w_fetching   = (r_state == S_W_FETCH) || (r_state == S_D_FETCH);
  // FIFO occupancy plus words still in flight never exceeds DEPTH, so rvalid
  // always finds a free slot.
  assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit     = (w_inflight < DEPTH_W);
  assign w_rd_req     = w_fetching && !r_wr_pend && (r_remain != '0) && w_credit;
  assign w_rd_gnt     = w_rd_req && mem_gnt;
  assign w_wr_gnt     = r_wr_pend && mem_gnt;
  // Returns with nothing outstanding (stale after a reset) are discarded.
  assign w_push       = mem_rvalid && (r_state != S_IDLE) && (r_outstanding != '0);
  assign w_fetch_done = (r_remain == '0) && (r_outstanding == '0) && w_empty;

  assign w_idle_or_wb = (r_state == S_IDLE) || (r_state == S_WB);
  assign w_w_ok       = w_load && w_idle_or_wb;
  assign w_d_ok       = d_load && (w_idle_or_wb || (r_state == S_W_FETCH));
  assign w_load_err   = (w_load && !w_idle_or_wb) || (d_load && !w_d_ok);
  assign w_nd_base    = w_d_ok ? cfg_d_base : r_d_base;
  assign w_nd_len     = w_d_ok ? cfg_d_len  : r_d_len;

  assign weight_rd_rdy = (r_state == S_W_FETCH) && !w_empty;
  assign data_rd_rdy   = (r_state == S_D_FETCH) && !w_empty;
  assign w_pop         = (weight_rd_rdy && weight_rd_acq) || (data_rd_rdy && data_rd_acq);
  assign rd_data       = w_empty ? '0 : r_fifo[r_rptr];

  assign dst_wr_acq = (r_state == S_WB) && !r_wr_pend && (r_wr_cnt < r_o_len);
  assign w_wr_take  = dst_wr_rdy && dst_wr_acq;

  // A pending write owns the memory port; reads wait until it is granted.
  assign mem_req   = w_rd_req || r_wr_pend;
  assign mem_we    = r_wr_pend;
  assign mem_addr  = r_wr_pend ? r_o_ptr : (w_rd_req ? r_rd_addr : '0);
  assign mem_wdata = r_wr_pend ? r_wdata : '0;

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

  // Phase sequencing, fetch address/remaining count and the result write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_remain  <= '0;
      r_d_base  <= '0;
      r_d_len   <= '0;
      r_o_len   <= '0;
      r_o_ptr   <= '0;
      r_wr_cnt  <= '0;
      r_wdata   <= '0;
      r_wr_pend <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load_err) r_err <= 1'b1;
      if (w_d_ok) begin
        r_d_base <= cfg_d_base;
        r_d_len  <= cfg_d_len;
        r_o_len  <= cfg_o_len;
      end
      if (w_rd_gnt) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_remain  <= r_remain - 1'b1;
      end
      if (w_wr_take) begin
        r_wr_pend <= 1'b1;
        r_wdata   <= dst_wr_data;
        r_wr_cnt  <= r_wr_cnt + 1'b1;
      end else if (w_wr_gnt) begin
        r_wr_pend <= 1'b0;
      end
      if (w_wr_gnt) r_o_ptr <= r_o_ptr + 1'b1;
      case (r_state)
        S_IDLE, S_WB: begin
          if (w_w_ok) begin
            r_state   <= S_W_FETCH;
            r_rd_addr <= cfg_w_base;
            r_remain  <= cfg_w_len;
            r_o_ptr   <= cfg_o_base;
          end else if (w_d_ok) begin
            r_state   <= S_D_FETCH;
            r_rd_addr <= cfg_d_base;
            r_remain  <= cfg_d_len;
          end else if ((r_state == S_WB) && (r_wr_cnt >= r_o_len) && !r_wr_pend) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_W_FETCH: begin
          if (w_fetch_done) begin
            r_state   <= S_D_FETCH;
            r_rd_addr <= w_nd_base;
            r_remain  <= w_nd_len;
          end
        end
        default: begin
          if (w_fetch_done) begin
            r_state  <= S_WB;
            r_wr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and outstanding-read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_rd_gnt, w_push})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // FIFO storage; contents need no reset because rd_data is gated by empty.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= mem_rdata;
  end

`ifdef PA_AGENT_PERF_CNT_EN
  logic [31:0] r_perf;
  logic        w_stall;
  assign w_stall = (weight_rd_acq && !weight_rd_rdy) || (data_rd_acq && !data_rd_rdy);

  // Saturating count of cycles where the sequencer asks for a word that is not there.
  always_ff @(posedge clk) begin
    if (rst || w_w_ok) r_perf <= '0;
    else if (w_stall && (r_perf != 32'hFFFF_FFFF)) r_perf <= r_perf + 1'b1;
  end
  assign perf_stall = r_perf;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_pa_mem_agent.sv
// Testbench for pa_mem_agent: behavioural memory with grant stalls and
// configurable read latency, read-beat and write scoreboards.
module tb_pa_mem_agent;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, w_load, d_load;
  logic [AW-1:0] cfg_w_base, cfg_d_base, cfg_o_base;
  logic [31:0]   cfg_w_len, cfg_d_len, cfg_o_len;
  logic          weight_rd_acq, weight_rd_rdy, data_rd_acq, data_rd_rdy;
  logic [31:0]   rd_data;
  logic          dst_wr_rdy, dst_wr_acq;
  logic [31:0]   dst_wr_data;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          busy, done, err;
  logic [31:0]   perf_stall;
  logic [1:0]    dbg_state;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_DF = 2'd2, ST_WB = 2'd3;

  pa_mem_agent #(.AW(AW), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .d_load(d_load),
    .cfg_w_base(cfg_w_base), .cfg_w_len(cfg_w_len),
    .cfg_d_base(cfg_d_base), .cfg_d_len(cfg_d_len),
    .cfg_o_base(cfg_o_base), .cfg_o_len(cfg_o_len),
    .weight_rd_acq(weight_rd_acq), .weight_rd_rdy(weight_rd_rdy),
    .data_rd_acq(data_rd_acq), .data_rd_rdy(data_rd_rdy), .rd_data(rd_data),
    .dst_wr_rdy(dst_wr_rdy), .dst_wr_data(dst_wr_data), .dst_wr_acq(dst_wr_acq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .perf_stall(perf_stall), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard queues
  logic [31:0]   exp_w_q[$];
  logic [31:0]   exp_d_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [31:0]   exp_wd_q[$];
  logic [AW-1:0] exp_optr = '0;

  typedef struct { logic [31:0] d; int due; } rd_ent_t;
  rd_ent_t rd_q[$];

  // memory model knobs and statistics
  int g_stall = 0, extra_lat = 0, gnt_budget = -1, stall_ctr = 0, cyc = 0;
  int rd_grants = 0, wr_grants = 0, wr_out = 0;
  int w_beats = 0, d_beats = 0, done_cnt = 0;
  int stall_model = 0;
  bit stall_en = 1'b0;
  bit g_taken = 1'b0, g_we = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [31:0]   g_wdata = '0;

  function automatic logic [31:0] md(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // memory responder and output monitor, evaluated on the falling edge
  initial begin
    logic [31:0] v;
    logic [AW-1:0] a;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (g_taken) begin
        if (g_we) begin
          wr_grants++;
          wr_out--;
          n_checks++;
          if (exp_wa_q.size() == 0) begin
            n_errors++;
            $display("FAIL wr_unexpected addr=%h data=%h", g_addr, g_wdata);
          end else begin
            a = exp_wa_q.pop_front();
            v = exp_wd_q.pop_front();
            if (g_addr !== a || g_wdata !== v) begin
              n_errors++;
              $display("FAIL wr_txn got addr=%h data=%h exp addr=%h data=%h", g_addr, g_wdata, a, v);
            end
          end
        end else begin
          rd_grants++;
          rd_q.push_back('{md(g_addr), cyc + 1 + extra_lat});
        end
      end
      if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_q[0].d;
        void'(rd_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      g_taken = 1'b0;
      if (mem_req && !rst && gnt_budget != 0) begin
        if (stall_ctr >= g_stall) begin
          g_taken = 1'b1; g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
          stall_ctr = 0;
          if (gnt_budget > 0) gnt_budget--;
        end else begin
          stall_ctr++;
        end
      end
      mem_gnt = g_taken;
      if (!rst) begin
        if (weight_rd_rdy && weight_rd_acq) begin
          w_beats++;
          n_checks++;
          if (exp_w_q.size() == 0) begin
            n_errors++; $display("FAIL w_beat_unexpected got=%h", rd_data);
          end else begin
            v = exp_w_q.pop_front();
            if (rd_data !== v) begin n_errors++; $display("FAIL w_beat got=%h exp=%h", rd_data, v); end
          end
        end
        if (data_rd_rdy && data_rd_acq) begin
          d_beats++;
          n_checks++;
          if (exp_d_q.size() == 0) begin
            n_errors++; $display("FAIL d_beat_unexpected got=%h", rd_data);
          end else begin
            v = exp_d_q.pop_front();
            if (rd_data !== v) begin n_errors++; $display("FAIL d_beat got=%h exp=%h", rd_data, v); end
          end
        end
        if (wr_out > 0) begin
          n_checks++;
          if (dst_wr_acq !== 1'b0) begin n_errors++; $display("FAIL acq_while_pending got=%b exp=0", dst_wr_acq); end
        end
        if (dst_wr_rdy && dst_wr_acq) begin
          exp_wa_q.push_back(exp_optr);
          exp_wd_q.push_back(dst_wr_data);
          exp_optr = exp_optr + 1;
          wr_out++;
        end
        if (done) done_cnt++;
        if (stall_en && ((weight_rd_acq && !weight_rd_rdy) || (data_rd_acq && !data_rd_rdy))) stall_model++;
      end
    end
  end

  // driver tasks
  task automatic do_w_load(input logic [AW-1:0] base, input logic [31:0] len, input logic [AW-1:0] obase);
    @(posedge clk); #1;
    cfg_w_base = base; cfg_w_len = len; cfg_o_base = obase; w_load = 1'b1;
    for (int i = 0; i < int'(len); i++) exp_w_q.push_back(md(base + AW'(i)));
    exp_optr = obase;
    @(posedge clk); #1;
    w_load = 1'b0;
  endtask

  task automatic do_d_load(input logic [AW-1:0] base, input logic [31:0] len, input logic [31:0] olen, input bit accepted);
    @(posedge clk); #1;
    cfg_d_base = base; cfg_d_len = len; cfg_o_len = olen; d_load = 1'b1;
    if (accepted) for (int i = 0; i < int'(len); i++) exp_d_q.push_back(md(base + AW'(i)));
    @(posedge clk); #1;
    d_load = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < max && !ok; t++) begin
      @(negedge clk);
      if (dbg_state === s) ok = 1'b1;
    end
  endtask

  task automatic drive_results(input int n);
    bit got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dst_wr_rdy = 1'b1; dst_wr_data = $urandom;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        if (dst_wr_acq) got = 1'b1;
      end
      n_checks++;
      if (!got) begin n_errors++; $display("FAIL wr_acq_timeout got=0 exp=1 idx=%0d", i); end
    end
    @(posedge clk); #1;
    dst_wr_rdy = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [1:0] s, input bit ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL %s got_state=%0d exp_state=%0d", name, dbg_state, s); end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; w_load = 0; d_load = 0; weight_rd_acq = 0; data_rd_acq = 0;
    dst_wr_rdy = 0; dst_wr_data = '0;
    cfg_w_base = '0; cfg_w_len = '0; cfg_d_base = '0; cfg_d_len = '0; cfg_o_base = '0; cfg_o_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, mem_req, mem_we, weight_rd_rdy, data_rd_rdy, dst_wr_acq} !== 8'b0) begin
      n_errors++; $display("FAIL reset_flags got=%b exp=00000000", {busy, done, err, mem_req, mem_we, weight_rd_rdy, data_rd_rdy, dst_wr_acq});
    end
    n_checks++;
    if (rd_data !== 32'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      n_errors++; $display("FAIL reset_data got rd=%h addr=%h wd=%h exp 0", rd_data, mem_addr, mem_wdata);
    end
    n_checks++;
    if (perf_stall !== 32'h0) begin n_errors++; $display("FAIL reset_perf got=%0d exp=0", perf_stall); end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_weight_stream();
    bit ok;
    int wb0 = w_beats;
    weight_rd_acq = 1'b1;
    do_w_load(32'h100, 4, 32'h400);
    do_d_load(32'h200, 20, 16, 1'b1);
    wait_state(ST_DF, 100, ok);
    check_state("w_to_dfetch", ST_DF, ok);
    n_checks++;
    if (w_beats - wb0 != 4 || exp_w_q.size() != 0) begin
      n_errors++; $display("FAIL w_beat_count got=%0d exp=4 left=%0d", w_beats - wb0, exp_w_q.size());
    end
    weight_rd_acq = 1'b0;
  endtask

  task automatic test_data_backpressure();
    bit ok;
    int g0 = rd_grants;
    int db0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (rd_grants - g0 != 8) begin n_errors++; $display("FAIL prefetch_reads got=%0d exp=8", rd_grants - g0); end
    n_checks++;
    if (mem_req !== 1'b0 || data_rd_rdy !== 1'b1) begin
      n_errors++; $display("FAIL prefetch_hold got req=%b rdy=%b exp req=0 rdy=1", mem_req, data_rd_rdy);
    end
    db0 = d_beats;
    @(posedge clk); #1 data_rd_acq = 1'b1;
    wait_state(ST_WB, 200, ok);
    check_state("d_to_wb", ST_WB, ok);
    n_checks++;
    if (d_beats - db0 != 20 || exp_d_q.size() != 0 || data_rd_rdy !== 1'b0) begin
      n_errors++; $display("FAIL d_stream got beats=%0d left=%0d rdy=%b exp beats=20 left=0 rdy=0", d_beats - db0, exp_d_q.size(), data_rd_rdy);
    end
    data_rd_acq = 1'b0;
  endtask

  task automatic test_write_phase();
    bit ok;
    int wg0 = wr_grants;
    int dc0 = done_cnt;
    g_stall = 3;
    drive_results(16);
    wait_state(ST_IDLE, 100, ok);
    check_state("wb_to_idle", ST_IDLE, ok);
    n_checks++;
    if (wr_grants - wg0 != 16 || exp_wa_q.size() != 0 || done_cnt - dc0 != 1) begin
      n_errors++; $display("FAIL wr_phase got writes=%0d left=%0d done=%0d exp 16/0/1", wr_grants - wg0, exp_wa_q.size(), done_cnt - dc0);
    end
    g_stall = 0;
  endtask

  task automatic test_load_error_and_zero_len();
    bit ok;
    int db0 = d_beats;
    int wg0;
    data_rd_acq = 1'b1;
    do_d_load(32'h300, 6, 2, 1'b1);
    do_d_load(32'h380, 3, 5, 1'b0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin n_errors++; $display("FAIL err_on_dload got=%b exp=1", err); end
    wait_state(ST_WB, 100, ok);
    check_state("seg_to_wb", ST_WB, ok);
    n_checks++;
    if (d_beats - db0 != 6 || exp_d_q.size() != 0) begin
      n_errors++; $display("FAIL seg_beats got=%0d exp=6 left=%0d", d_beats - db0, exp_d_q.size());
    end
    wg0 = wr_grants;
    drive_results(2);
    wait_state(ST_IDLE, 50, ok);
    check_state("seg_wb_idle", ST_IDLE, ok);
    n_checks++;
    if (wr_grants - wg0 != 2) begin n_errors++; $display("FAIL seg_writes got=%0d exp=2", wr_grants - wg0); end
    do_d_load(32'h320, 0, 0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_DF || data_rd_rdy !== 1'b0) begin
      n_errors++; $display("FAIL zlen_c1 got state=%0d rdy=%b exp 2/0", dbg_state, data_rd_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_WB || data_rd_rdy !== 1'b0) begin
      n_errors++; $display("FAIL zlen_c2 got state=%0d rdy=%b exp 3/0", dbg_state, data_rd_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_IDLE || done !== 1'b1 || err !== 1'b1) begin
      n_errors++; $display("FAIL zlen_c3 got state=%0d done=%b err=%b exp 0/1/1", dbg_state, done, err);
    end
    data_rd_acq = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit ok;
    bit bad;
    int g0 = rd_grants;
    int wb0;
    int dc0;
    extra_lat = 8;
    gnt_budget = 3;
    do_w_load(32'h500, 10, 32'h480);
    ok = 1'b0;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if (rd_grants - g0 == 3) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rst_setup got grants=%0d exp=3", rd_grants - g0); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    gnt_budget = -1;
    exp_w_q.delete();
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, mem_req, weight_rd_rdy, data_rd_rdy, dst_wr_acq} !== 7'b0 || rd_data !== 32'h0 || perf_stall !== 32'h0 || dbg_state !== ST_IDLE) begin
      n_errors++; $display("FAIL rst_mid_outputs got busy=%b err=%b req=%b wrdy=%b rd=%h st=%0d exp all 0", busy, err, mem_req, weight_rd_rdy, rd_data, dbg_state);
    end
    bad = 1'b0;
    for (int t = 0; t < 30 && rd_q.size() != 0; t++) begin
      @(negedge clk);
      if (weight_rd_rdy || busy || rd_data !== 32'h0) bad = 1'b1;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bad || rd_q.size() != 0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL stale_rvalid got bad=%b pending=%0d busy=%b exp 0/0/0", bad, rd_q.size(), busy);
    end
    extra_lat = 0;
    wb0 = w_beats;
    dc0 = done_cnt;
    weight_rd_acq = 1'b1;
    do_w_load(32'h600, 5, 32'h500);
    wait_state(ST_IDLE, 100, ok);
    check_state("post_rst_idle", ST_IDLE, ok);
    n_checks++;
    if (w_beats - wb0 != 5 || exp_w_q.size() != 0 || err !== 1'b0 || done_cnt - dc0 != 1) begin
      n_errors++; $display("FAIL post_rst_stream got beats=%0d left=%0d err=%b done=%0d exp 5/0/0/1", w_beats - wb0, exp_w_q.size(), err, done_cnt - dc0);
    end
    @(posedge clk); #1 weight_rd_acq = 1'b0;
  endtask

  task automatic test_perf();
    bit ok;
    logic [31:0] exp_perf;
    extra_lat = 4;
    do_w_load(32'h700, 1, 32'h500);
    weight_rd_acq = 1'b1;
    stall_model = 0;
    stall_en = 1'b1;
    wait_state(ST_IDLE, 100, ok);
    check_state("perf_idle", ST_IDLE, ok);
    @(posedge clk); #1;
    weight_rd_acq = 1'b0;
    stall_en = 1'b0;
    @(negedge clk);
`ifdef PA_AGENT_PERF_CNT_EN
    exp_perf = 32'(stall_model);
`else
    exp_perf = 32'h0;
`endif
    n_checks++;
    if (perf_stall !== exp_perf || exp_w_q.size() != 0) begin
      n_errors++; $display("FAIL perf_stall got=%0d exp=%0d left=%0d", perf_stall, exp_perf, exp_w_q.size());
    end
    extra_lat = 0;
  endtask

  initial begin
    test_reset();
    test_weight_stream();
    test_data_backpressure();
    test_write_phase();
    test_load_error_and_zero_len();
    test_reset_midflight();
    test_perf();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
